// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, register-zero address,
// the control bundle carried from ID through EX/MEM, and the forwarding select encoding.
package mips_pkg;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = ctrl_t'(5'b00000);

  typedef enum logic [1:0] {
    FWD_CAP = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// One EX operand forwarding select: captured value, EX/MEM result or MEM/WB result.
// The youngest producer (EX/MEM) wins; register zero is never forwarded.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] cap_data,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] data
);

  fwd_sel_e sel;

  always_comb begin
    sel  = FWD_CAP;
    data = cap_data;
    if (src == {RW{1'b0}}) begin
      sel = FWD_CAP;
    end else if (mem_reg_write && (mem_dst == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_dst == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_CAP;
    end
    case (sel)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_result;
      default: data = cap_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use stall detection.
// Optional macro ID_EX_PERF_EN adds stall/flush/forward performance counters.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [CW-1:0] id_alu_ctl,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_branch,
  input  logic          flush,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
`ifdef ID_EX_PERF_EN
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_fwd_cnt,
`endif
  output logic          ex_branch
);

  logic          valid_q, valid_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [CW-1:0] alu_ctl_q, alu_ctl_d;
  logic          alu_src_q, alu_src_d;
  ctrl_t         ctrl_q, ctrl_d, id_ctrl;
  logic          load_use;
  logic [DW-1:0] fwd_rs, fwd_rt;

  function automatic logic wb_hit(input logic we, input logic [RW-1:0] dst,
                                  input logic [RW-1:0] src);
    return we && (dst != {RW{1'b0}}) && (dst == src);
  endfunction

  always_comb begin
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.branch     = id_branch;
    // rt only matters when it feeds the ALU or supplies store data
    load_use = valid_q && ctrl_q.mem_read && (dst_q != {RW{1'b0}}) &&
               ((dst_q == id_rs) || ((dst_q == id_rt) && (!id_alu_src || id_mem_write)));
    stall = load_use && id_valid && !flush;
  end

  always_comb begin
    valid_d   = 1'b0;
    rs_d      = {RW{1'b0}};
    rt_d      = {RW{1'b0}};
    dst_d     = {RW{1'b0}};
    rs_data_d = {DW{1'b0}};
    rt_data_d = {DW{1'b0}};
    imm_d     = {DW{1'b0}};
    alu_ctl_d = CW'(ALUCTL_AND);
    alu_src_d = 1'b0;
    ctrl_d    = CTRL_NOP;
    if (flush || stall) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d   = id_valid;
      rs_d      = id_rs;
      rt_d      = id_rt;
      dst_d     = id_dst;
      rs_data_d = wb_hit(wb_reg_write, wb_dst, id_rs) ? wb_result : id_rs_data;
      rt_data_d = wb_hit(wb_reg_write, wb_dst, id_rt) ? wb_result : id_rt_data;
      imm_d     = id_imm;
      alu_ctl_d = id_alu_ctl;
      alu_src_d = id_alu_src;
      ctrl_d    = id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_q      <= {RW{1'b0}};
      rt_q      <= {RW{1'b0}};
      dst_q     <= {RW{1'b0}};
      rs_data_q <= {DW{1'b0}};
      rt_data_q <= {DW{1'b0}};
      imm_q     <= {DW{1'b0}};
      alu_ctl_q <= {CW{1'b0}};
      alu_src_q <= 1'b0;
      ctrl_q    <= CTRL_NOP;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dst_q     <= dst_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alu_ctl_q <= alu_ctl_d;
      alu_src_q <= alu_src_d;
      ctrl_q    <= ctrl_d;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src(rs_q), .cap_data(rs_data_q),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
    .data(fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src(rt_q), .cap_data(rt_data_q),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
    .data(fwd_rt)
  );

  always_comb begin
    alu_a         = fwd_rs;
    alu_b         = alu_src_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    alu_ctl       = alu_ctl_q;
    ex_valid      = valid_q;
    ex_dst        = dst_q;
    // a bubble must never write anything, even if control state were corrupted
    ex_reg_write  = ctrl_q.reg_write && valid_q;
    ex_mem_write  = ctrl_q.mem_write && valid_q;
    ex_mem_read   = ctrl_q.mem_read && valid_q;
    ex_mem_to_reg = ctrl_q.mem_to_reg && valid_q;
    ex_branch     = ctrl_q.branch && valid_q;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic        fwd_any;

  always_comb begin
    fwd_any = valid_q &&
              (wb_hit(mem_reg_write, mem_dst, rs_q) || wb_hit(wb_reg_write, wb_dst, rs_q) ||
               (!alu_src_q && (wb_hit(mem_reg_write, mem_dst, rt_q) ||
                               wb_hit(wb_reg_write, wb_dst, rt_q))));
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = flush ? flush_cnt_q + 32'd1 : flush_cnt_q;
    fwd_cnt_d   = fwd_any ? fwd_cnt_q + 32'd1 : fwd_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding priority, register zero,
// load-use stall, flush, ID bypass, store data and reset during a stall.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_ctl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_dst, wb_dst;
  logic [31:0] mem_result, wb_result;
  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctl;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_ctl(id_alu_ctl), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_dst = 5'd0;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_alu_ctl = 4'd0;
    id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; id_branch = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_dst = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0; wb_dst = 5'd0; wb_result = 32'd0;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic src, input logic rw, input logic mr, input logic mw);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_ctl = ALUCTL_ADD;
    id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = mr; id_branch = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    drive_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      vecs++;
      if ({ex_valid, ex_reg_write, ex_mem_write, stall} !== 4'b0000) begin
        errs++; $display("FAIL reset_ctl cyc%0d: got %b want 0000", c, {ex_valid, ex_reg_write, ex_mem_write, stall});
      end
      vecs++;
      if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctl !== 4'd0) begin
        errs++; $display("FAIL reset_alu cyc%0d: a=%h b=%h ctl=%b want 0", c, alu_a, alu_b, alu_ctl);
      end
    end
    reset = 1'b0;
    idle_all();
    tick();
  endtask

  task automatic test_mem_fwd();
    drive_id(5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_all();
    mem_reg_write = 1'b1; mem_dst = 5'd5; mem_result = 32'h10;
    settle();
    vecs++;
    if (alu_a !== 32'h10 || alu_b !== 32'h2 || alu_ctl !== ALUCTL_ADD || ex_valid !== 1'b1) begin
      errs++; $display("FAIL mem_fwd: a=%h b=%h ctl=%b v=%b want 10 2 0010 1", alu_a, alu_b, alu_ctl, ex_valid);
    end
    wb_reg_write = 1'b1; wb_dst = 5'd5; wb_result = 32'h20;
    settle();
    vecs++;
    if (alu_a !== 32'h10) begin
      errs++; $display("FAIL mem_over_wb: a=%h want 10", alu_a);
    end
    mem_reg_write = 1'b0;
    settle();
    vecs++;
    if (alu_a !== 32'h20) begin
      errs++; $display("FAIL wb_fwd: a=%h want 20", alu_a);
    end
    idle_all();
    tick();
  endtask

  task automatic test_rd0();
    drive_id(5'd0, 5'd4, 5'd9, 32'h33, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_all();
    mem_reg_write = 1'b1; mem_dst = 5'd0; mem_result = 32'hFF;
    wb_reg_write = 1'b1; wb_dst = 5'd0; wb_result = 32'hEE;
    settle();
    vecs++;
    if (alu_a !== 32'h33 || alu_b !== 32'h44) begin
      errs++; $display("FAIL rd0_no_fwd: a=%h b=%h want 33 44", alu_a, alu_b);
    end
    idle_all();
    tick();
  endtask

  task automatic test_load_use();
    drive_id(5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    vecs++;
    if (alu_a !== 32'h100 || alu_b !== 32'h4 || ex_mem_read !== 1'b1 || ex_dst !== 5'd8) begin
      errs++; $display("FAIL lw_issue: a=%h b=%h mr=%b dst=%0d want 100 4 1 8", alu_a, alu_b, ex_mem_read, ex_dst);
    end
    drive_id(5'd8, 5'd2, 5'd9, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    vecs++;
    if (stall !== 1'b1) begin
      errs++; $display("FAIL lu_stall: stall=%b want 1", stall);
    end
    tick();
    mem_reg_write = 1'b1; mem_dst = 5'd8; mem_result = 32'h104;
    settle();
    vecs++;
    if ({stall, ex_valid, ex_reg_write} !== 3'b000 || alu_a !== 32'd0) begin
      errs++; $display("FAIL lu_bubble: st/v/rw=%b a=%h want 000 0", {stall, ex_valid, ex_reg_write}, alu_a);
    end
    tick();
    idle_all();
    wb_reg_write = 1'b1; wb_dst = 5'd8; wb_result = 32'hCAFE;
    settle();
    vecs++;
    if (ex_valid !== 1'b1 || alu_a !== 32'hCAFE || alu_b !== 32'h7 || ex_dst !== 5'd9 || stall !== 1'b0) begin
      errs++; $display("FAIL lu_reissue: v=%b a=%h b=%h dst=%0d st=%b want 1 cafe 7 9 0", ex_valid, alu_a, alu_b, ex_dst, stall);
    end
    idle_all();
    tick();
  endtask

  task automatic test_flush();
    drive_id(5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(5'd8, 5'd2, 5'd9, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    settle();
    vecs++;
    if (stall !== 1'b0) begin
      errs++; $display("FAIL flush_stall: stall=%b want 0", stall);
    end
    tick();
    idle_all();
    settle();
    vecs++;
    if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) begin
      errs++; $display("FAIL flush_bubble: v/rw/mr=%b want 000", {ex_valid, ex_reg_write, ex_mem_read});
    end
    tick();
  endtask

  task automatic test_bypass();
    drive_id(5'd3, 5'd4, 5'd10, 32'h0, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    wb_reg_write = 1'b1; wb_dst = 5'd3; wb_result = 32'hABCD;
    tick();
    idle_all();
    settle();
    vecs++;
    if (alu_a !== 32'hABCD || alu_b !== 32'h5) begin
      errs++; $display("FAIL id_bypass: a=%h b=%h want abcd 5", alu_a, alu_b);
    end
    tick();
  endtask

  task automatic test_store_and_invalid();
    drive_id(5'd2, 5'd3, 5'd0, 32'h40, 32'h55, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle_all();
    mem_reg_write = 1'b1; mem_dst = 5'd3; mem_result = 32'h77;
    settle();
    vecs++;
    if (ex_store_data !== 32'h77 || alu_b !== 32'h8 || alu_a !== 32'h40 || ex_mem_write !== 1'b1) begin
      errs++; $display("FAIL store_fwd: sd=%h b=%h a=%h mw=%b want 77 8 40 1", ex_store_data, alu_b, alu_a, ex_mem_write);
    end
    idle_all();
    id_valid = 1'b0; id_reg_write = 1'b1; id_mem_write = 1'b1; id_dst = 5'd6;
    tick();
    vecs++;
    if ({ex_valid, ex_reg_write, ex_mem_write} !== 3'b000) begin
      errs++; $display("FAIL invalid_ctl: v/rw/mw=%b want 000", {ex_valid, ex_reg_write, ex_mem_write});
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_id(5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(5'd8, 5'd2, 5'd9, 32'h0, 32'h7, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    vecs++;
    if (stall !== 1'b1) begin
      errs++; $display("FAIL rst_stall_pre: stall=%b want 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    vecs++;
    if ({stall, ex_valid, ex_reg_write} !== 3'b000 || alu_b !== 32'd0) begin
      errs++; $display("FAIL rst_stall_post: st/v/rw=%b b=%h want 000 0", {stall, ex_valid, ex_reg_write}, alu_b);
    end
    idle_all();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_mem_fwd();
    test_rd0();
    test_load_use();
    test_flush();
    test_bypass();
    test_store_and_invalid();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
